// File: rtl/tage_predictor_param.sv
// Parametrised TAGE direction predictor: bimodal base plus NUM_TABLES tagged tables,
// registered lookup, update from returned meta/GHR snapshot, allocation and u aging.
module tage_predictor_param #(
    parameter int                      NUM_TABLES = 4,
    parameter int                      IDX_W      = 10,
    parameter int                      TAG_W      = 8,
    parameter int                      BASE_IDX_W = 12,
    parameter int                      GHR_DEPTH  = 64,
    parameter logic [8*NUM_TABLES-1:0] HIST_LENS  = {8'd40, 8'd20, 8'd10, 8'd5},
    parameter int                      AGE_W      = 18
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    pc_i,
    input  logic                           pc_valid_i,
    input  logic                           update_valid_i,
    input  logic [31:0]                    update_pc_i,
    input  logic                           update_taken_i,
    input  logic [5:0]                     update_meta_i,
    input  logic [GHR_DEPTH-1:0]           update_ghr_i,
    output logic                           predict_valid_o,
    output logic                           predict_taken_o,
    output logic [5:0]                     predict_meta_o,
    output logic [GHR_DEPTH-1:0]           predict_ghr_o,
    output logic [32*(NUM_TABLES+1)-1:0]   perf_hit_count_o
);
    localparam int TBL_SZ    = 1 << IDX_W;
    localparam int BASE_SZ   = 1 << BASE_IDX_W;
    localparam int IDX_CHUNK = (GHR_DEPTH + IDX_W - 1) / IDX_W;
    localparam int TAG_CHUNK = (GHR_DEPTH + TAG_W - 1) / TAG_W;

    // Folding by shift-and-XOR keeps the zero padding of the last chunk implicit.
    function automatic logic [IDX_W-1:0] fold_idx(input logic [GHR_DEPTH-1:0] h, input int len);
        logic [GHR_DEPTH-1:0] hm;
        logic [IDX_W-1:0]     r;
        hm = (len >= GHR_DEPTH) ? h : (h & ((GHR_DEPTH'(1) << len) - GHR_DEPTH'(1)));
        r  = '0;
        for (int c = 0; c < IDX_CHUNK; c++) begin
            r  = r ^ IDX_W'(hm);
            hm = hm >> IDX_W;
        end
        return r;
    endfunction

    function automatic logic [TAG_W-1:0] fold_tag(input logic [GHR_DEPTH-1:0] h, input int len);
        logic [GHR_DEPTH-1:0] hm;
        logic [TAG_W-1:0]     r;
        hm = (len >= GHR_DEPTH) ? h : (h & ((GHR_DEPTH'(1) << len) - GHR_DEPTH'(1)));
        r  = '0;
        for (int c = 0; c < TAG_CHUNK; c++) begin
            r  = r ^ TAG_W'(hm);
            hm = hm >> TAG_W;
        end
        return r;
    endfunction

    function automatic logic [2:0] sat3(input logic [2:0] c, input logic up);
        if (up) return (c == 3'd7) ? c : c + 3'd1;
        return (c == 3'd0) ? c : c - 3'd1;
    endfunction

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'd3) ? c : c + 2'd1;
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    logic [1:0]           base_q [BASE_SZ];
    logic                 tval_q [NUM_TABLES][TBL_SZ];
    logic [TAG_W-1:0]     ttag_q [NUM_TABLES][TBL_SZ];
    logic [2:0]           tctr_q [NUM_TABLES][TBL_SZ];
    logic [1:0]           tu_q   [NUM_TABLES][TBL_SZ];
    logic [GHR_DEPTH-1:0] ghr_q, ghr_d;
    logic [AGE_W-1:0]     age_q, age_d;
    logic                 age_wrap;

    logic                 pvalid_q, ptaken_q;
    logic [5:0]           pmeta_q;
    logic [GHR_DEPTH-1:0] pghr_q;
    logic [31:0]          perf_q [NUM_TABLES+1];

    logic [IDX_W-1:0]      lk_idx [NUM_TABLES];
    logic [TAG_W-1:0]      lk_tag [NUM_TABLES];
    logic [IDX_W-1:0]      up_idx [NUM_TABLES];
    logic [TAG_W-1:0]      up_tag [NUM_TABLES];
    logic [BASE_IDX_W-1:0] lk_base_idx, up_base_idx;
    logic [3:0]            lk_prov, up_prov, alloc_tbl;
    logic                  lk_prov_pred, lk_alt_pred;
    logic                  up_pp, up_ap, up_mispred, alloc_found;
    logic                  unused_pc;

    for (genvar g = 0; g < NUM_TABLES; g++) begin : g_hash
        assign lk_idx[g] = pc_i[2 +: IDX_W] ^ fold_idx(ghr_q, int'(HIST_LENS[8*g +: 8]));
        assign lk_tag[g] = pc_i[2+IDX_W +: TAG_W] ^ fold_tag(ghr_q, int'(HIST_LENS[8*g +: 8]));
        assign up_idx[g] = update_pc_i[2 +: IDX_W] ^ fold_idx(update_ghr_i, int'(HIST_LENS[8*g +: 8]));
        assign up_tag[g] = update_pc_i[2+IDX_W +: TAG_W] ^ fold_tag(update_ghr_i, int'(HIST_LENS[8*g +: 8]));
    end

    assign lk_base_idx = pc_i[2 +: BASE_IDX_W];
    assign up_base_idx = update_pc_i[2 +: BASE_IDX_W];
    assign unused_pc   = ^{pc_i, update_pc_i};

    // Ascending scan: each new hit demotes the previous provider to alt.
    always_comb begin
        lk_prov      = 4'd0;
        lk_prov_pred = base_q[lk_base_idx][1];
        lk_alt_pred  = base_q[lk_base_idx][1];
        for (int t = 0; t < NUM_TABLES; t++) begin
            if (tval_q[t][lk_idx[t]] && (ttag_q[t][lk_idx[t]] == lk_tag[t])) begin
                lk_alt_pred  = lk_prov_pred;
                lk_prov      = 4'(t + 1);
                lk_prov_pred = tctr_q[t][lk_idx[t]][2];
            end
        end
    end

    assign up_prov    = update_meta_i[5:2];
    assign up_pp      = update_meta_i[1];
    assign up_ap      = update_meta_i[0];
    assign up_mispred = (up_pp != update_taken_i);

    // Descending scan so the lowest eligible table wins.
    always_comb begin
        alloc_found = 1'b0;
        alloc_tbl   = 4'd0;
        for (int t = NUM_TABLES - 1; t >= 0; t--) begin
            if ((4'(t + 1) > up_prov) && (tu_q[t][up_idx[t]] == 2'd0)) begin
                alloc_found = 1'b1;
                alloc_tbl   = 4'(t + 1);
            end
        end
    end

    assign ghr_d    = {ghr_q[GHR_DEPTH-2:0], update_taken_i};
    assign age_d    = age_q + AGE_W'(1);
    assign age_wrap = (age_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BASE_SZ; b++) base_q[b] <= 2'b10;
            for (int t = 0; t < NUM_TABLES; t++) begin
                for (int i = 0; i < TBL_SZ; i++) begin
                    tval_q[t][i] <= 1'b0;
                    ttag_q[t][i] <= '0;
                    tctr_q[t][i] <= 3'b100;
                    tu_q[t][i]   <= 2'd0;
                end
            end
            ghr_q <= '0;
            age_q <= '0;
        end else if (update_valid_i) begin
            ghr_q <= ghr_d;
            age_q <= age_d;
            if (up_prov == 4'd0) base_q[up_base_idx] <= sat2(base_q[up_base_idx], update_taken_i);
            for (int t = 0; t < NUM_TABLES; t++) begin
                if (4'(t + 1) == up_prov) begin
                    tctr_q[t][up_idx[t]] <= sat3(tctr_q[t][up_idx[t]], update_taken_i);
                    if (up_pp != up_ap)
                        tu_q[t][up_idx[t]] <= sat2(tu_q[t][up_idx[t]], up_pp == update_taken_i);
                end
                if (up_mispred && alloc_found && (4'(t + 1) == alloc_tbl)) begin
                    tval_q[t][up_idx[t]] <= 1'b1;
                    ttag_q[t][up_idx[t]] <= up_tag[t];
                    tctr_q[t][up_idx[t]] <= update_taken_i ? 3'b100 : 3'b011;
                    tu_q[t][up_idx[t]]   <= 2'd0;
                end
                if (up_mispred && !alloc_found && (4'(t + 1) > up_prov))
                    tu_q[t][up_idx[t]] <= sat2(tu_q[t][up_idx[t]], 1'b0);
            end
            // Placed last so aging wins over any u write in the same cycle.
            if (age_wrap) begin
                for (int t = 0; t < NUM_TABLES; t++)
                    for (int i = 0; i < TBL_SZ; i++) tu_q[t][i] <= tu_q[t][i] >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pvalid_q <= 1'b0;
            ptaken_q <= 1'b0;
            pmeta_q  <= '0;
            pghr_q   <= '0;
            for (int k = 0; k <= NUM_TABLES; k++) perf_q[k] <= '0;
        end else begin
            pvalid_q <= pc_valid_i;
            if (pc_valid_i) begin
                ptaken_q        <= lk_prov_pred;
                pmeta_q         <= {lk_prov, lk_prov_pred, lk_alt_pred};
                pghr_q          <= ghr_q;
                perf_q[lk_prov] <= perf_q[lk_prov] + 32'd1;
            end
        end
    end

    assign predict_valid_o = pvalid_q;
    assign predict_taken_o = ptaken_q;
    assign predict_meta_o  = pmeta_q;
    assign predict_ghr_o   = pghr_q;

    for (genvar g = 0; g <= NUM_TABLES; g++) begin : g_perf
        assign perf_hit_count_o[32*g +: 32] = perf_q[g];
    end

endmodule

// File: tb/tb_tage_predictor_param.sv
// Directed bench for tage_predictor_param: reset, allocation, hazard, no-candidate,
// aging and mid-operation reset, all observed through the ports.
module tb_tage_predictor_param;
    localparam int NT = 4;
    localparam int GD = 64;

    localparam logic [31:0] PC_R0 = 32'h1c000000;
    localparam logic [31:0] PC_P  = 32'h1c000040;
    localparam logic [31:0] PC_PN = 32'h1c001040;
    localparam logic [31:0] PC_Q  = 32'h00000800;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     pc_i = '0;
    logic            pc_valid_i = 1'b0;
    logic            update_valid_i = 1'b0;
    logic [31:0]     update_pc_i = '0;
    logic            update_taken_i = 1'b0;
    logic [5:0]      update_meta_i = '0;
    logic [GD-1:0]   update_ghr_i = '0;
    logic            predict_valid_o;
    logic            predict_taken_o;
    logic [5:0]      predict_meta_o;
    logic [GD-1:0]   predict_ghr_o;
    logic [32*(NT+1)-1:0] perf_hit_count_o;

    int n_vec = 0;
    int n_err = 0;

    tage_predictor_param #(.AGE_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .pc_valid_i       (pc_valid_i),
        .update_valid_i   (update_valid_i),
        .update_pc_i      (update_pc_i),
        .update_taken_i   (update_taken_i),
        .update_meta_i    (update_meta_i),
        .update_ghr_i     (update_ghr_i),
        .predict_valid_o  (predict_valid_o),
        .predict_taken_o  (predict_taken_o),
        .predict_meta_o   (predict_meta_o),
        .predict_ghr_o    (predict_ghr_o),
        .perf_hit_count_o (perf_hit_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int k);
        return perf_hit_count_o[32*k +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        pc_i       = pc;
        pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [3:0] prov, input logic pp,
                          input logic ap, input logic taken);
        update_pc_i    = pc;
        update_meta_i  = {prov, pp, ap};
        update_taken_i = taken;
        update_ghr_i   = '0;
        update_valid_i = 1'b1;
        tick();
        update_valid_i = 1'b0;
    endtask

    task automatic expect_pred(input string tag, input logic taken, input logic [5:0] meta);
        chk({tag, "_valid"}, 64'(predict_valid_o), 64'(1'b1));
        chk({tag, "_taken"}, 64'(predict_taken_o), 64'(taken));
        chk({tag, "_meta"},  64'(predict_meta_o),  64'(meta));
    endtask

    initial begin
        // reset state and first lookup
        tick();
        do_reset();
        chk("rst_valid", 64'(predict_valid_o), 64'(1'b0));
        chk("rst_meta",  64'(predict_meta_o),  64'(6'b0));
        chk("rst_perf0", 64'(slot(0)),         64'(32'd0));
        lookup(PC_R0);
        expect_pred("rst_lk", 1'b1, 6'b0000_1_1);
        chk("rst_lk_perf0", 64'(slot(0)), 64'(32'd1));
        tick();
        chk("hold_valid", 64'(predict_valid_o), 64'(1'b0));
        chk("hold_taken", 64'(predict_taken_o), 64'(1'b1));
        chk("hold_meta",  64'(predict_meta_o),  64'(6'b0000_1_1));

        // allocation into table 1 after a base mispredict
        do_reset();
        update(PC_P, 4'd0, 1'b1, 1'b1, 1'b0);
        lookup(PC_P);
        expect_pred("alloc", 1'b0, 6'b0001_0_0);
        chk("alloc_perf1", 64'(slot(1)), 64'(32'd1));
        chk("alloc_perf0", 64'(slot(0)), 64'(32'd0));
        chk("alloc_ghr",   predict_ghr_o, 64'd0);

        // same-cycle lookup and allocating update
        do_reset();
        pc_i           = PC_P;
        pc_valid_i     = 1'b1;
        update_pc_i    = PC_P;
        update_meta_i  = {4'd0, 1'b1, 1'b1};
        update_taken_i = 1'b0;
        update_ghr_i   = '0;
        update_valid_i = 1'b1;
        tick();
        pc_valid_i     = 1'b0;
        update_valid_i = 1'b0;
        expect_pred("hazard_old", 1'b1, 6'b0000_1_1);
        lookup(PC_P);
        expect_pred("hazard_new", 1'b0, 6'b0001_0_0);

        // no free candidate, then allocation once u has been decremented
        do_reset();
        update(PC_P, 4'd1, 1'b1, 1'b1, 1'b0);
        update(PC_P, 4'd2, 1'b0, 1'b1, 1'b0);
        update(PC_P, 4'd2, 1'b1, 1'b1, 1'b0);
        update(PC_P, 4'd3, 1'b0, 1'b1, 1'b0);
        update(PC_P, 4'd3, 1'b1, 1'b1, 1'b0);
        update(PC_P, 4'd4, 1'b0, 1'b1, 1'b0);
        lookup(PC_P);
        expect_pred("nc_pre", 1'b0, 6'b0100_0_0);
        update(PC_PN, 4'd1, 1'b1, 1'b1, 1'b0);
        lookup(PC_PN);
        expect_pred("nc_noalloc", 1'b1, 6'b0000_1_1);
        update(PC_PN, 4'd1, 1'b1, 1'b1, 1'b0);
        lookup(PC_PN);
        expect_pred("nc_alloc_t2", 1'b0, 6'b0010_0_1);
        lookup(PC_P);
        expect_pred("nc_p_after", 1'b0, 6'b0100_0_0);

        // aging on the 16th update overrides a same-cycle u increment
        do_reset();
        update(PC_P, 4'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) update(PC_P, 4'd4, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) update(PC_Q, 4'd0, 1'b0, 1'b0, 1'b0);
        update(PC_P, 4'd4, 1'b0, 1'b1, 1'b0);
        update(PC_PN, 4'd3, 1'b1, 1'b1, 1'b0);
        lookup(PC_PN);
        expect_pred("age_noalloc", 1'b1, 6'b0000_1_1);
        lookup(PC_P);
        expect_pred("age_p_kept", 1'b0, 6'b0100_0_1);
        update(PC_PN, 4'd3, 1'b1, 1'b1, 1'b0);
        lookup(PC_PN);
        expect_pred("age_alloc_t4", 1'b0, 6'b0100_0_1);
        lookup(PC_P);
        expect_pred("age_p_evicted", 1'b1, 6'b0000_1_1);

        // reset in the middle of traffic
        do_reset();
        update(PC_P, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) update(PC_Q, 4'd0, 1'b1, 1'b1, 1'b1);
        lookup(PC_P);
        expect_pred("mid_pre", 1'b1, 6'b0000_1_1);
        chk("mid_pre_ghr", predict_ghr_o, 64'h3ff);
        rst            = 1'b1;
        pc_i           = PC_P;
        pc_valid_i     = 1'b1;
        update_pc_i    = PC_P;
        update_meta_i  = {4'd0, 1'b0, 1'b0};
        update_taken_i = 1'b1;
        update_valid_i = 1'b1;
        tick();
        rst            = 1'b0;
        pc_valid_i     = 1'b0;
        update_valid_i = 1'b0;
        chk("mid_rst_valid", 64'(predict_valid_o), 64'(1'b0));
        chk("mid_rst_taken", 64'(predict_taken_o), 64'(1'b0));
        chk("mid_rst_meta",  64'(predict_meta_o),  64'(6'b0));
        chk("mid_rst_ghr",   predict_ghr_o,        64'd0);
        chk("mid_rst_perf0", 64'(slot(0)),         64'(32'd0));
        lookup(PC_P);
        expect_pred("mid_post", 1'b1, 6'b0000_1_1);
        chk("mid_post_ghr",   predict_ghr_o, 64'd0);
        chk("mid_post_perf0", 64'(slot(0)),  64'(32'd1));
        chk("mid_post_perf1", 64'(slot(1)),  64'(32'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
